apb_req_arbiter: RTL

Round-robin arbiter sharing one `apb_master` system-task port between `N_REQ` independent requesters. It latches one request, drives the master's `addr`/`data`/`data_dir`/`data_valid` inputs, and waits for `transaction_done`. It then returns read data and a completion (or timeout-error) pulse to the owning requester. It sits between the system-side request sources and `apb_master`; the APB bus side is untouched.

---
 rtl/apb_arb_pkg.sv | 18 +
 rtl/apb_rr_picker.sv | 38 +++
 rtl/apb_req_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter and its helpers.
//   arb_state_t : arbiter FSM states
//   APB_ADDR_W  : master address width
//   APB_DATA_W  : master data width
//   WDOG_W      : width of the BUSY watchdog counter
package apb_arb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;
  localparam int WDOG_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker.
// Searches req_valid starting at last_grant+1 (wrapping at N_REQ) and returns
// the first set index.
//   req_valid  in  N_REQ  request vector
//   last_grant in  IDX_W  index granted most recently
//   grant_idx  out IDX_W  winning index (holds last_grant when nothing requests)
//   any_req    out 1      at least one request is set
module apb_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  always_comb begin
    int cand;
    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    grant_idx = last_grant;
    any_req   = 1'b0;
    cand      = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(last_grant) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      // The first hit in search order wins; later hits are ignored.
      if (!any_req && req_valid[cand[IDX_W-1:0]]) begin
        any_req   = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apb_master system-task port between N_REQ
// requesters. One request is latched into the m_* fields, held until the
// master reports transaction_done (or the watchdog expires), and the result is
// returned to the owning requester as a one-cycle pulse.
//   apb_clk, sys_reset            clock, async active-low reset
//   req_valid/addr/data/dir  in   per-requester request, packed per index
//   req_done/req_err         out  one-hot completion / error pulses
//   rd_data                  out  read data, valid while any req_done is high
//   m_addr/m_data/m_data_dir out  latched fields to the master
//   m_data_valid             out  transfer request to the master
//   m_read_out_data, m_done  in   master read data and completion
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                         apb_clk,
  input  logic                         sys_reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [APB_ADDR_W*N_REQ-1:0]  req_addr,
  input  logic [APB_DATA_W*N_REQ-1:0]  req_data,
  input  logic [N_REQ-1:0]             req_dir,
  output logic [N_REQ-1:0]             req_done,
  output logic [N_REQ-1:0]             req_err,
  output logic [APB_DATA_W-1:0]        rd_data,
  output logic [APB_ADDR_W-1:0]        m_addr,
  output logic [APB_DATA_W-1:0]        m_data,
  output logic                         m_data_dir,
  output logic                         m_data_valid,
  input  logic [APB_DATA_W-1:0]        m_read_out_data,
  input  logic                         m_done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  last_grant_q;
  logic [IDX_W-1:0]  grant_idx;
  logic              any_req;
  logic [WDOG_W-1:0] wdog_q;
  logic              wdog_expire;

  // Unpacked views of the packed request buses, indexed by requester.
  logic [APB_ADDR_W-1:0] addr_arr [N_REQ];
  logic [APB_DATA_W-1:0] data_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[APB_ADDR_W*i +: APB_ADDR_W];
    assign data_arr[i] = req_data[APB_DATA_W*i +: APB_DATA_W];
  end

  apb_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  // The watchdog holds the number of BUSY cycles already spent without
  // m_done, so the current cycle is the TIMEOUT-th one when it reads
  // TIMEOUT-1. m_done in that same cycle takes priority.
  assign wdog_expire = (state_q == BUSY) && !m_done && (wdog_q == WDOG_LAST);

  // Gated combinationally so the master, back in IDLE in the m_done cycle,
  // never sees a stale request and launches a second transfer.
  assign m_data_valid = (state_q == BUSY) && !m_done;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req)             state_d = BUSY;
      BUSY:    if (m_done || wdog_expire) state_d = GAP;
      GAP:                              state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_ff @(posedge apb_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge apb_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      last_grant_q <= LAST_IDX;
      wdog_q       <= '0;
      m_addr       <= '0;
      m_data       <= '0;
      m_data_dir   <= 1'b0;
      req_done     <= '0;
      req_err      <= '0;
      rd_data      <= '0;
    end else begin
      req_done <= '0;
      req_err  <= '0;
      unique case (state_q)
        IDLE: begin
          wdog_q <= '0;
          if (any_req) begin
            last_grant_q <= grant_idx;
            m_addr       <= addr_arr[grant_idx];
            m_data       <= data_arr[grant_idx];
            m_data_dir   <= req_dir[grant_idx];
          end
        end
        BUSY: begin
          if (m_done) begin
            req_done[last_grant_q] <= 1'b1;
            rd_data                <= m_read_out_data;
          end else if (wdog_expire) begin
            req_done[last_grant_q] <= 1'b1;
            req_err[last_grant_q]  <= 1'b1;
            rd_data                <= '0;
          end else if (wdog_q != WDOG_MAX) begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
